// File: rtl/prg_dma_loader.sv
// Converts HPS ioctl download streams (PRG files or raw RAM images) into byte writes
// on a DMA port with backpressure, finishing PRG loads with the BASIC end pointers.
module prg_dma_loader #(
    parameter int          AW        = 16,
    parameter logic [7:0]  PRG_INDEX = 8'h41,
    parameter logic [7:0]  IMG_INDEX = 8'h00,
    parameter int unsigned IMG_LO    = 'h0400,
    parameter int unsigned IMG_HI    = 'h8000,
    parameter int unsigned IMG_BASE  = 'h8000,
    parameter int unsigned RAM_TOP   = 'h8000,
    parameter int unsigned PTR_BASE  = 'h002A,
    parameter int unsigned NPTR      = 3
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ioctl_download,
    input  logic [7:0]    i_ioctl_index,
    input  logic          i_ioctl_wr,
    input  logic [24:0]   i_ioctl_addr,
    input  logic [7:0]    i_ioctl_dout,
    output logic          o_ioctl_wait,
    output logic [AW-1:0] o_dma_addr,
    output logic [7:0]    o_dma_din,
    output logic          o_dma_we,
    input  logic          i_dma_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_overflow,
    output logic          o_short_file,
    output logic [AW-1:0] o_end_addr
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_PTR, S_DONE} state_t;

    localparam logic [24:0]   LP_IMG_LO   = IMG_LO[24:0];
    localparam logic [24:0]   LP_IMG_HI   = IMG_HI[24:0];
    localparam logic [AW-1:0] LP_IMG_BASE = IMG_BASE[AW-1:0];
    localparam logic [AW:0]   LP_RAM_TOP  = RAM_TOP[AW:0];
    localparam logic [AW-1:0] LP_PTR_BASE = PTR_BASE[AW-1:0];
    localparam logic [3:0]    LP_NPB      = 4'(2 * NPTR);

    state_t        r_state;
    logic          r_dl_prev;
    logic          r_img;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_pidx;
    logic          r_pending;
    logic [AW-1:0] r_dma_addr;
    logic [7:0]    r_dma_din;
    logic          r_busy;
    logic          r_done;
    logic          r_ovf;
    logic          r_short;

    logic w_wait;
    logic w_start;
    logic w_acc;
    logic w_consume;
    logic w_free;

    assign w_wait    = r_pending | (r_state == S_PTR);
    assign w_start   = i_ioctl_download & ~r_dl_prev;
    assign w_acc     = i_ioctl_wr & ~w_wait;
    assign w_consume = r_pending & i_dma_ready;
    assign w_free    = ~r_pending | i_dma_ready;

    assign o_ioctl_wait = w_wait;
    assign o_dma_addr   = r_dma_addr;
    assign o_dma_din    = r_dma_din;
    assign o_dma_we     = r_pending;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_overflow   = r_ovf;
    assign o_short_file = r_short;
    assign o_end_addr   = r_addr;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_dl_prev  <= 1'b0;
            r_img      <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_pidx     <= '0;
            r_pending  <= 1'b0;
            r_dma_addr <= '0;
            r_dma_din  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            r_dl_prev <= i_ioctl_download;
            r_done    <= 1'b0;
            // A consumed entry is cleared here; any load below in the same cycle overrides it.
            if (w_consume) r_pending <= 1'b0;

            if (w_start && (i_ioctl_index == PRG_INDEX || i_ioctl_index == IMG_INDEX)) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_pidx <= '0;
                if (i_ioctl_index == PRG_INDEX) begin
                    r_state <= S_HDR;
                    r_img   <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_short <= 1'b0;
                end else begin
                    r_state <= S_DATA;
                    r_img   <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_HDR: begin
                        if (!i_ioctl_download) begin
                            r_short <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (w_acc) begin
                            r_cnt <= (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
                            if (i_ioctl_addr == 25'd0) begin
                                r_addr[7:0] <= i_ioctl_dout;
                            end else if (i_ioctl_addr == 25'd1) begin
                                r_addr  <= AW'({i_ioctl_dout, r_addr[7:0]});
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (!i_ioctl_download) begin
                            if (r_img) begin
                                if (!r_pending) begin
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end
                            end else if (r_cnt != 2'd3) begin
                                r_short <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else if (!r_pending) begin
                                r_state <= S_PTR;
                            end
                        end else if (w_acc) begin
                            if (r_img) begin
                                if (i_ioctl_addr >= LP_IMG_LO && i_ioctl_addr < LP_IMG_HI) begin
                                    r_pending  <= 1'b1;
                                    r_dma_addr <= i_ioctl_addr[AW-1:0] + LP_IMG_BASE;
                                    r_dma_din  <= i_ioctl_dout;
                                end
                            end else begin
                                r_cnt <= (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
                                if ({1'b0, r_addr} >= LP_RAM_TOP) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_pending  <= 1'b1;
                                    r_dma_addr <= r_addr;
                                    r_dma_din  <= i_ioctl_dout;
                                    r_addr     <= r_addr + 1'b1;
                                end
                            end
                        end
                    end
                    S_PTR: begin
                        // Next pointer byte is issued as soon as the buffer frees, with no bubble.
                        if (r_pidx == LP_NPB) begin
                            if (w_free) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else if (w_free) begin
                            r_pending  <= 1'b1;
                            r_dma_addr <= LP_PTR_BASE + AW'(r_pidx);
                            r_dma_din  <= r_pidx[0] ? r_addr[15:8] : r_addr[7:0];
                            r_pidx     <= r_pidx + 4'd1;
                        end
                    end
                    S_DONE: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prg_dma_loader.sv
// Randomized bench for prg_dma_loader: a file-level reference model predicts the DMA
// write list and status flags, and a monitor collects the accepted writes.
module tb_prg_dma_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        dma_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        short_file;
    logic [15:0] end_addr;

    always #5 clk = ~clk;

    prg_dma_loader dut (
        .i_clk(clk), .i_reset(rst),
        .i_ioctl_download(ioctl_download), .i_ioctl_index(ioctl_index),
        .i_ioctl_wr(ioctl_wr), .i_ioctl_addr(ioctl_addr), .i_ioctl_dout(ioctl_dout),
        .o_ioctl_wait(ioctl_wait),
        .o_dma_addr(dma_addr), .o_dma_din(dma_din), .o_dma_we(dma_we), .i_dma_ready(dma_ready),
        .o_busy(busy), .o_done(done), .o_overflow(overflow), .o_short_file(short_file),
        .o_end_addr(end_addr)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [23:0] wq[$];
    logic [23:0] exp_q[$];
    logic [7:0]  fb[64];
    int          done_cnt;
    bit          wait_err;
    int          rmode;
    int          exp_end;
    bit          exp_ovf, exp_short;
    int          exp_done;

    always @(posedge clk) if (dma_we && dma_ready) wq.push_back({dma_addr, dma_din});

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (dma_we && !ioctl_wait) wait_err = 1'b1;
    end

    initial begin
        int c = 0;
        forever begin
            @(negedge clk);
            c++;
            case (rmode)
                0: dma_ready = 1'b1;
                1: dma_ready = (c % 4 == 0);
                2: dma_ready = 1'($urandom % 2);
                default: ;
            endcase
        end
    end

    // File-level model: what writes and flags a whole download should produce.
    task automatic model(input logic [7:0] idx, input int off0, input int n);
        int a;
        int off;
        exp_q.delete();
        exp_ovf = 0; exp_short = 0; exp_done = 0; exp_end = 0;
        if (idx == 8'h41) begin
            if (n < 3) begin
                exp_short = 1;
            end else begin
                a = int'(fb[0]) + 256 * int'(fb[1]);
                for (int i = 2; i < n; i++) begin
                    if (a < 'h8000) begin
                        exp_q.push_back({16'(a), fb[i]});
                        a++;
                    end else begin
                        exp_ovf = 1;
                    end
                end
                exp_end = a;
                for (int k = 0; k < 6; k++)
                    exp_q.push_back({16'('h2A + k), (k % 2 == 1) ? 8'(a >> 8) : 8'(a)});
                exp_done = 1;
            end
        end else if (idx == 8'h00) begin
            for (int i = 0; i < n; i++) begin
                off = off0 + i;
                if (off >= 'h400 && off < 'h8000) exp_q.push_back({16'(off + 'h8000), fb[i]});
            end
        end
    endtask

    task automatic send(input logic [7:0] idx, input int off0, input int n, input bit wait_end);
        int t;
        wq.delete();
        done_cnt = 0;
        wait_err = 1'b0;
        @(negedge clk);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (ioctl_wait && t < 1000) begin @(negedge clk); t++; end
            if (t >= 1000) chk("wait_timeout", 1, 0);
            ioctl_addr = 25'(off0 + i);
            ioctl_dout = fb[i];
            ioctl_wr = 1'b1;
            @(negedge clk);
            ioctl_wr = 1'b0;
            repeat ($urandom % 2) @(negedge clk);
        end
        ioctl_download = 1'b0;
        if (wait_end) begin
            @(negedge clk);
            t = 0;
            while (busy && t < 2000) begin @(negedge clk); t++; end
            if (t >= 2000) chk("busy_timeout", 1, 0);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic check_result(input string nm, input logic [7:0] idx, input int n);
        chk({nm, ".wr_count"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            chk({nm, ".wr_addr"}, wq[i][23:8], exp_q[i][23:8]);
            chk({nm, ".wr_data"}, wq[i][7:0], exp_q[i][7:0]);
        end
        chk({nm, ".done_cnt"}, done_cnt, exp_done);
        chk({nm, ".busy"}, busy, 0);
        chk({nm, ".wait_vs_pending"}, wait_err, 0);
        if (idx == 8'h41) begin
            chk({nm, ".overflow"}, overflow, exp_ovf);
            chk({nm, ".short_file"}, short_file, exp_short);
            if (n >= 3) chk({nm, ".end_addr"}, end_addr, exp_end);
        end
    endtask

    task automatic run(input string nm, input logic [7:0] idx, input int off0, input int n);
        model(idx, off0, n);
        send(idx, off0, n, 1'b1);
        check_result(nm, idx, n);
    endtask

    initial begin
        int n;
        int a;
        int off0;
        int t;
        rst = 1'b1;
        ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        dma_ready = 1'b1; rmode = 0;
        repeat (3) @(negedge clk);
        chk("rst.dma_we", dma_we, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.overflow", overflow, 0);
        chk("rst.short_file", short_file, 0);
        chk("rst.end_addr", end_addr, 0);
        chk("rst.ioctl_wait", ioctl_wait, 0);
        chk("rst.dma_addr", dma_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        fb[0] = 8'h01; fb[1] = 8'h04; fb[2] = 8'hAA; fb[3] = 8'hBB; fb[4] = 8'hCC;
        rmode = 0;
        run("prg_basic", 8'h41, 0, 5);
        rmode = 1;
        run("prg_slow", 8'h41, 0, 5);

        rmode = 0;
        fb[0] = 8'hFE; fb[1] = 8'h7F;
        for (int i = 2; i < 6; i++) fb[i] = 8'(8'h10 + i);
        run("prg_ovf", 8'h41, 0, 6);

        fb[0] = 8'h00; fb[1] = 8'h10;
        run("prg_short", 8'h41, 0, 2);

        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
        run("img_edge", 8'h00, 'h3FF, 3);

        run("other_idx", 8'h22, 0, 3);

        for (int it = 0; it < 25; it++) begin
            rmode = $urandom % 3;
            n = $urandom_range(0, 20);
            a = ($urandom % 2 == 1) ? $urandom_range(0, 'h7FFF) : $urandom_range('h7FF0, 'h7FFF);
            fb[0] = 8'(a);
            fb[1] = 8'(a >> 8);
            for (int i = 2; i < 64; i++) fb[i] = 8'($urandom);
            run("prg_rand", 8'h41, 0, n);
        end

        for (int it = 0; it < 10; it++) begin
            rmode = $urandom % 3;
            n = $urandom_range(1, 20);
            off0 = ($urandom % 2 == 1) ? $urandom_range('h3F0, 'h410) : $urandom_range('h7FF0, 'h8010);
            for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
            run("img_rand", 8'h00, off0, n);
        end

        // Reset in the middle of the pointer sequence.
        rmode = 3;
        dma_ready = 1'b1;
        fb[0] = 8'h01; fb[1] = 8'h04; fb[2] = 8'hAA; fb[3] = 8'hBB; fb[4] = 8'hCC;
        model(8'h41, 0, 5);
        send(8'h41, 0, 5, 1'b0);
        t = 0;
        while (wq.size() < 5 && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) chk("rst_mid.timeout", 1, 0);
        chk("rst_mid.we_before", dma_we, 1);
        dma_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.we_after", dma_we, 0);
        chk("rst_mid.busy", busy, 0);
        rst = 1'b0;
        dma_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid.wr_count", wq.size(), 5);
        for (int i = 0; i < 5 && i < wq.size(); i++) chk("rst_mid.wr", wq[i], exp_q[i]);
        chk("rst_mid.done", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
